// File: rtl/bitbang_receiver_n_if.sv
// Output word stream of the bit-bang receiver: head word, valid and ready.
interface bitbang_receiver_n_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] m_data;
  logic              m_valid;
  logic              m_ready;

  modport master (output m_data, output m_valid, input m_ready);
  modport slave  (input m_data, input m_valid, output m_ready);
endinterface

// File: rtl/bitbang_receiver_n.sv
// Bit-bang link deserialiser: synchronised RxD/RxC/RxR, selectable bit order,
// optional idle timeout, and a first-word-fall-through output FIFO.
module bitbang_receiver_n #(
  parameter int DATA_W      = 8,
  parameter int MSB_FIRST   = 0,
  parameter int SYNC_STAGES = 2,
  parameter int FIFO_DEPTH  = 4,
  parameter int TIMEOUT     = 0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        RxD,
  input  logic                        RxC,
  input  logic                        RxR,
  bitbang_receiver_n_if.master        m,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        RxD_idle,
  output logic                        overflow,
  output logic                        timeout_err
);

  localparam int CNT_W = $clog2(DATA_W);
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int TMO_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);
  localparam logic [AW:0]      DEPTH_C  = (AW + 1)'(FIFO_DEPTH);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  // Input synchronisers and strobe edge detect
  logic [SYNC_STAGES-1:0] rxd_sync_q, rxc_sync_q, rxr_sync_q;
  logic                   rxc_q;
  logic                   rxd_s, rxc_s, rxr_s, bit_stb;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rxd_sync_q <= '0;
      rxc_sync_q <= '0;
      rxr_sync_q <= '0;
      rxc_q      <= 1'b0;
    end else begin
      rxd_sync_q <= {rxd_sync_q[SYNC_STAGES-2:0], RxD};
      rxc_sync_q <= {rxc_sync_q[SYNC_STAGES-2:0], RxC};
      rxr_sync_q <= {rxr_sync_q[SYNC_STAGES-2:0], RxR};
      rxc_q      <= rxc_s;
    end
  end

  assign rxd_s   = rxd_sync_q[SYNC_STAGES-1];
  assign rxc_s   = rxc_sync_q[SYNC_STAGES-1];
  assign rxr_s   = rxr_sync_q[SYNC_STAGES-1];
  assign bit_stb = rxc_s & ~rxc_q;

  // Shift register, bit counter and idle timer
  logic [DATA_W-1:0] shreg_q, shreg_d, shifted;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic              push_q, push_d;
  logic              terr_q, terr_d;

  always_comb begin
    cnt_d   = cnt_q;
    shreg_d = shreg_q;
    tmo_d   = tmo_q;
    push_d  = 1'b0;
    terr_d  = 1'b0;
    shifted = (MSB_FIRST != 0) ? {shreg_q[DATA_W-2:0], rxd_s}
                               : {rxd_s, shreg_q[DATA_W-1:1]};
    if (rxr_s) begin
      cnt_d   = '0;
      shreg_d = '0;
      tmo_d   = '0;
    end else if (bit_stb) begin
      tmo_d   = '0;
      shreg_d = shifted;
      if (cnt_q == CNT_LAST) begin
        cnt_d  = '0;
        push_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end else if (cnt_q == '0) begin
      tmo_d = '0;
    end else if (TIMEOUT > 0) begin
      if (tmo_q == TMO_LAST) begin
        cnt_d   = '0;
        shreg_d = '0;
        tmo_d   = '0;
        terr_d  = 1'b1;
      end else begin
        tmo_d = tmo_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      shreg_q <= '0;
      tmo_q   <= '0;
      push_q  <= 1'b0;
      terr_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      shreg_q <= shreg_d;
      tmo_q   <= tmo_d;
      push_q  <= push_d;
      terr_q  <= terr_d;
    end
  end

  // Output FIFO. The completed word is taken from shreg_q during the push
  // cycle: the next strobe cannot arrive before the cycle after that.
  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]       count_q, count_d;
  logic              ovf_q, ovf_d;
  logic              full, valid, pop, wr_en;

  assign full  = (count_q == DEPTH_C);
  assign valid = (count_q != '0);
  assign pop   = valid & m.m_ready;
  assign wr_en = push_q & (~full | pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)   rd_ptr_d = rd_ptr_q + 1'b1;
    case ({wr_en, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    if (rxr_s)
      ovf_d = 1'b0;
    else if (push_q && !wr_en)
      ovf_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (wr_en) mem_q[wr_ptr_q] <= shreg_q;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  assign m.m_data    = mem_q[rd_ptr_q];
  assign m.m_valid   = valid;
  assign fifo_count  = count_q;
  assign RxD_idle    = (cnt_q == '0);
  assign overflow    = ovf_q;
  assign timeout_err = terr_q;

endmodule

// File: tb/tb_bitbang_receiver_n.sv
// Bench: two receivers (LSB-first with timeout, MSB-first without) on one
// shared link, checked against a word-level scoreboard.
module tb_bitbang_receiver_n;
  localparam int DW    = 8;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst, RxD, RxC, RxR, rdy;
  always #5 clk = ~clk;

  bitbang_receiver_n_if #(.DATA_W(DW)) bus0 ();
  bitbang_receiver_n_if #(.DATA_W(DW)) bus1 ();
  assign bus0.m_ready = rdy;
  assign bus1.m_ready = rdy;

  logic [2:0] cnt0, cnt1;
  logic idle0, idle1, ovf0, ovf1, terr0, terr1;

  bitbang_receiver_n #(.DATA_W(DW), .MSB_FIRST(0), .SYNC_STAGES(2),
                       .FIFO_DEPTH(DEPTH), .TIMEOUT(100)) dut0 (
    .clk(clk), .rst(rst), .RxD(RxD), .RxC(RxC), .RxR(RxR), .m(bus0),
    .fifo_count(cnt0), .RxD_idle(idle0), .overflow(ovf0), .timeout_err(terr0));

  bitbang_receiver_n #(.DATA_W(DW), .MSB_FIRST(1), .SYNC_STAGES(3),
                       .FIFO_DEPTH(DEPTH), .TIMEOUT(0)) dut1 (
    .clk(clk), .rst(rst), .RxD(RxD), .RxC(RxC), .RxR(RxR), .m(bus1),
    .fifo_count(cnt1), .RxD_idle(idle1), .overflow(ovf1), .timeout_err(terr1));

  int n_chk = 0;
  int n_bad = 0;

  // Word-level reference: bits accumulated arithmetically, queues of expected words
  int         n0, n1, v0, v1, tc0, tc1;
  bit         mo0, mo1;
  logic [7:0] q0[$], q1[$];
  logic [7:0] last0, last1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic deliver0(input logic [7:0] w);
    if (q0.size() < DEPTH) q0.push_back(w);
    else mo0 = 1'b1;
  endtask

  task automatic deliver1(input logic [7:0] w);
    if (q1.size() < DEPTH) q1.push_back(w);
    else mo1 = 1'b1;
  endtask

  task automatic model_bit(input bit b);
    v0 = v0 + (int'(b) << n0);
    n0++;
    if (n0 == DW) begin
      deliver0(v0[7:0]);
      n0 = 0;
      v0 = 0;
    end
    v1 = v1 * 2 + int'(b);
    n1++;
    if (n1 == DW) begin
      deliver1(v1[7:0]);
      n1 = 0;
      v1 = 0;
    end
  endtask

  task automatic model_abort();
    n0 = 0; n1 = 0; v0 = 0; v1 = 0;
    mo0 = 1'b0; mo1 = 1'b0;
  endtask

  task automatic send_bit(input bit b);
    RxD = b;
    tick($urandom_range(1, 3));
    RxC = 1'b1;
    model_bit(b);
    tick($urandom_range(3, 6));
    RxC = 1'b0;
    tick($urandom_range(3, 6));
  endtask

  task automatic send_word(input logic [7:0] w);
    for (int i = 0; i < DW; i++) send_bit(w[i]);
  endtask

  task automatic pulse_rxr();
    RxR = 1'b1;
    tick(6);
    RxR = 1'b0;
    model_abort();
    tick(6);
  endtask

  task automatic settle();
    tick(8);
    chk("count0", cnt0, q0.size());
    chk("count1", cnt1, q1.size());
    chk("valid0", bus0.m_valid, q0.size() != 0);
    chk("valid1", bus1.m_valid, q1.size() != 0);
    chk("ovf0", ovf0, mo0);
    chk("ovf1", ovf1, mo1);
    chk("idle0", idle0, n0 == 0);
    chk("idle1", idle1, n1 == 0);
  endtask

  // Scoreboard: every accepted word must match the head of the expected queue
  always @(negedge clk) begin
    if (!rst) begin
      if (bus0.m_valid && rdy) begin
        chk("pop0_expected", q0.size() != 0, 1);
        if (q0.size() != 0) begin
          chk("pop0_data", bus0.m_data, q0[0]);
          last0 = bus0.m_data;
          void'(q0.pop_front());
        end
      end
      if (bus1.m_valid && rdy) begin
        chk("pop1_expected", q1.size() != 0, 1);
        if (q1.size() != 0) begin
          chk("pop1_data", bus1.m_data, q1[0]);
          last1 = bus1.m_data;
          void'(q1.pop_front());
        end
      end
      if (terr0) tc0++;
      if (terr1) tc1++;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] pat, w;
    logic [8:0] vm0, vm1;
    logic [7:0] d0, d1;

    rst = 1'b1; RxD = 1'b0; RxC = 1'b0; RxR = 1'b0; rdy = 1'b1;
    n0 = 0; n1 = 0; v0 = 0; v1 = 0; mo0 = 0; mo1 = 0; tc0 = 0; tc1 = 0;
    last0 = '0; last1 = '0;
    tick(3);
    chk("rst_count0", cnt0, 0);
    chk("rst_valid0", bus0.m_valid, 0);
    chk("rst_data0", bus0.m_data, 0);
    chk("rst_idle0", idle0, 1);
    chk("rst_ovf0", ovf0, 0);
    chk("rst_terr0", terr0, 0);
    chk("rst_valid1", bus1.m_valid, 0);
    rst = 1'b0;
    tick(3);

    // Bits 1,0,1,0,0,0,1,1 in sending order; bit i of pat is the i-th bit sent
    pat = 8'b1100_0101;
    for (int i = 0; i < DW - 1; i++) send_bit(pat[i]);
    RxD = pat[7];
    tick(2);
    RxC = 1'b1;
    model_bit(pat[7]);
    vm0 = '0; vm1 = '0; d0 = '0; d1 = '0;
    for (int c = 1; c <= 8; c++) begin
      tick(1);
      vm0[c] = bus0.m_valid;
      vm1[c] = bus1.m_valid;
      if (c == 4) begin
        d0  = bus0.m_data;
        RxC = 1'b0;
      end
      if (c == 5) d1 = bus1.m_data;
    end
    chk("lat_valid0", vm0, 9'h010);
    chk("lat_valid1", vm1, 9'h020);
    chk("word_lsb_c5", d0, 8'hC5);
    chk("word_msb_a3", d1, 8'hA3);
    settle();

    // Overflow with consumer stalled, then RxR keeps the full FIFO
    rdy = 1'b0;
    tick(4);
    for (int k = 1; k <= 5; k++) begin
      w = 8'(k * 8'h11);
      send_word(w);
    end
    settle();
    chk("ovf_count0", cnt0, 4);
    chk("ovf_flag0", ovf0, 1);
    chk("ovf_flag1", ovf1, 1);
    for (int i = 0; i < 5; i++) send_bit(1'($urandom_range(0, 1)));
    pulse_rxr();
    settle();
    chk("rxr_idle0", idle0, 1);
    chk("rxr_ovf0", ovf0, 0);
    chk("rxr_keep0", cnt0, 4);
    rdy = 1'b1;
    tick(8);
    chk("drain_last0", last0, 8'h44);
    chk("drain_valid0", bus0.m_valid, 0);
    settle();

    // Timeout drops a 3-bit partial word on dut0 only
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    tc0 = 0; tc1 = 0;
    n0 = 0; v0 = 0;
    tick(150);
    chk("tmo_pulse0", tc0, 1);
    chk("tmo_pulse1", tc1, 0);
    chk("tmo_idle0", idle0, 1);
    chk("tmo_idle1", idle1, 0);
    send_word(8'hFF);
    settle();
    chk("tmo_word0", last0, 8'hFF);
    pulse_rxr();
    settle();

    // RxR mid-word with two words buffered
    rdy = 1'b0;
    tick(4);
    send_word(8'($urandom));
    send_word(8'($urandom));
    for (int i = 0; i < 5; i++) send_bit(1'($urandom_range(0, 1)));
    pulse_rxr();
    settle();
    chk("rxr2_count0", cnt0, 2);
    chk("rxr2_count1", cnt1, 2);
    rdy = 1'b1;
    tick(8);
    send_word(8'h3C);
    settle();
    chk("rxr2_word0", last0, 8'h3C);

    // Async reset mid-word with FIFO non-empty
    rdy = 1'b0;
    tick(4);
    send_word(8'($urandom));
    send_word(8'($urandom));
    send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("arst_count0", cnt0, 0);
    chk("arst_valid0", bus0.m_valid, 0);
    chk("arst_data0", bus0.m_data, 0);
    chk("arst_idle0", idle0, 1);
    chk("arst_count1", cnt1, 0);
    chk("arst_idle1", idle1, 1);
    q0.delete();
    q1.delete();
    model_abort();
    tick(3);
    rst = 1'b0;
    tick(3);
    rdy = 1'b1;
    tick(2);
    send_word(8'h5A);
    settle();
    chk("arst_word0", last0, 8'h5A);
    chk("arst_word1", last1, 8'h5A);

    // Randomised words, consumer readiness and occasional aborts
    for (int k = 0; k < 24; k++) begin
      rdy = ($urandom_range(0, 3) != 0);
      tick(8);
      if ($urandom_range(0, 7) == 0) begin
        for (int i = 0; i < int'($urandom_range(1, 7)); i++)
          send_bit(1'($urandom_range(0, 1)));
        pulse_rxr();
      end
      send_word(8'($urandom));
      settle();
    end

    rdy = 1'b1;
    tick(10);
    chk("final_q0", q0.size(), 0);
    chk("final_q1", q1.size(), 0);
    settle();

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
